// File: rtl/io_ctrl_pkg.sv
// Register map and seven-segment glyph table shared by the board I/O controller.
package io_ctrl_pkg;

  localparam logic [4:0] ADDR_LED  = 5'h00;
  localparam logic [4:0] ADDR_HEX  = 5'h04;
  localparam logic [4:0] ADDR_CTRL = 5'h08;
  localparam logic [4:0] ADDR_SW   = 5'h0C;
  localparam logic [4:0] ADDR_STAT = 5'h10;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is left off here and applied by the scanner.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    g = 8'hFF;
    case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      4'hF: g = 8'h8E;
      default: g = 8'hFF;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus stability counter; accepts a switch vector once it has held steady.
module sw_debounce
  import io_ctrl_pkg::*;
#(
  parameter int unsigned SW_WIDTH   = 24,
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SW_WIDTH-1:0] switch,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                changed_c
);

  localparam int unsigned   CNT_W   = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync1;
  logic [SW_WIDTH-1:0] sync2;
  logic [CNT_W-1:0]    cnt;

  assign changed_c = (cnt == CNT_MAX) && (sync2 != sw_stable);

  // Comparing sync1 against sync2 lets the counter read 0 in the very cycle sync2 takes a new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= '0;
      sync2     <= '0;
      cnt       <= '0;
      sw_stable <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (changed_c) begin
        sw_stable <= sync2;
      end
    end
  end

endmodule

// File: rtl/mmio_io_ctrl.sv
// Memory-mapped LED / switch / seven-segment controller on the CPU IO window.
module mmio_io_ctrl
  import io_ctrl_pkg::*;
#(
  parameter int unsigned SW_WIDTH   = 24,
  parameter int unsigned LED_WIDTH  = 24,
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned SCAN_DIV   = 100000,
  parameter int unsigned DEB_CYCLES = 200000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 io_write,
  input  logic                 io_read,
  input  logic [4:0]           addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [SW_WIDTH-1:0]  switch,
  output logic [LED_WIDTH-1:0] led,
  output logic [DIGITS-1:0]    dig,
  output logic [7:0]           seg
);

  localparam int unsigned HEX_W = 4 * DIGITS;
  localparam int unsigned SC_W  = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  logic [HEX_W-1:0]     hex_q, hex_nxt;
  logic [DIGITS-1:0]    en_q, en_nxt, dp_q, dp_nxt;
  logic [LED_WIDTH-1:0] led_nxt;
  logic                 sw_changed, sw_changed_nxt;
  logic [SW_WIDTH-1:0]  sw_stable;
  logic                 deb_changed_c;
  logic [SC_W-1:0]      scan_cnt, scan_nxt;
  logic [IDX_W-1:0]     digit_idx, idx_nxt;
  logic [4:0]           offset_c;
  logic [31:0]          rd_c;
  logic [DIGITS-1:0]    onehot_c, dig_nxt;
  logic [7:0]           glyph_c, seg_nxt;
  logic                 en_sel_c, dp_sel_c;
  logic                 unused_c;

  assign offset_c = {addr[4:2], 2'b00};
  assign unused_c = ^{addr[1:0], wdata};

  sw_debounce #(
    .SW_WIDTH  (SW_WIDTH),
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .switch   (switch),
    .sw_stable(sw_stable),
    .changed_c(deb_changed_c)
  );

  // Read mux sees pre-write state, so a simultaneous read returns the old value.
  always_comb begin
    rd_c = '0;
    case (offset_c)
      ADDR_LED:  rd_c = 32'(led);
      ADDR_HEX:  rd_c = 32'(hex_q);
      ADDR_CTRL: rd_c = 32'(en_q) | (32'(dp_q) << 8);
      ADDR_SW:   rd_c = 32'(sw_stable);
      ADDR_STAT: rd_c = {31'b0, sw_changed};
      default:   rd_c = '0;
    endcase
  end

  always_comb begin
    led_nxt        = led;
    hex_nxt        = hex_q;
    en_nxt         = en_q;
    dp_nxt         = dp_q;
    sw_changed_nxt = sw_changed;
    if (io_write) begin
      case (offset_c)
        ADDR_LED:  led_nxt = wdata[LED_WIDTH-1:0];
        ADDR_HEX:  hex_nxt = wdata[HEX_W-1:0];
        ADDR_CTRL: begin
          en_nxt = wdata[DIGITS-1:0];
          dp_nxt = wdata[8 +: DIGITS];
        end
        ADDR_STAT: if (wdata[0]) sw_changed_nxt = 1'b0;
        default: ;
      endcase
    end
    if (deb_changed_c) begin
      sw_changed_nxt = 1'b1;
    end
  end

  // Display is decoded from next-state values so dig and seg always match the live slot and registers.
  always_comb begin
    scan_nxt = scan_cnt + SC_W'(1);
    idx_nxt  = digit_idx;
    if (scan_cnt == SC_MAX) begin
      scan_nxt = '0;
      idx_nxt  = (digit_idx == IDX_MAX) ? '0 : digit_idx + IDX_W'(1);
    end
    onehot_c = DIGITS'(1) << idx_nxt;
    en_sel_c = |(en_nxt & onehot_c);
    dp_sel_c = |(dp_nxt & onehot_c);
    glyph_c  = hex_glyph(4'(hex_nxt >> {idx_nxt, 2'b00}));
    dig_nxt  = '1;
    seg_nxt  = 8'hFF;
    if (en_sel_c) begin
      dig_nxt = ~onehot_c;
      seg_nxt = {glyph_c[7] & ~dp_sel_c, glyph_c[6:0]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led        <= '0;
      hex_q      <= '0;
      en_q       <= '0;
      dp_q       <= '0;
      sw_changed <= 1'b0;
      rdata      <= '0;
      scan_cnt   <= '0;
      digit_idx  <= '0;
      dig        <= '1;
      seg        <= 8'hFF;
    end else begin
      led        <= led_nxt;
      hex_q      <= hex_nxt;
      en_q       <= en_nxt;
      dp_q       <= dp_nxt;
      sw_changed <= sw_changed_nxt;
      scan_cnt   <= scan_nxt;
      digit_idx  <= idx_nxt;
      dig        <= dig_nxt;
      seg        <= seg_nxt;
      if (io_read) begin
        rdata <= rd_c;
      end
    end
  end

endmodule

// File: tb/tb_mmio_io_ctrl.sv
// Randomised and directed bench for mmio_io_ctrl against a behavioural register/display model.
module tb_mmio_io_ctrl;

  localparam int unsigned SW_W   = 24;
  localparam int unsigned LED_W  = 24;
  localparam int unsigned DIGITS = 8;
  localparam int unsigned SCAN   = 4;
  localparam int unsigned DEB    = 4;
  localparam logic [31:0] CTRL_MASK = 32'h0000FFFF;
  localparam logic [7:0]  SEG_TBL [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              io_write = 1'b0;
  logic              io_read = 1'b0;
  logic [4:0]        addr = '0;
  logic [31:0]       wdata = '0;
  logic [31:0]       rdata;
  logic [SW_W-1:0]   switch = '0;
  logic [LED_W-1:0]  led;
  logic [DIGITS-1:0] dig;
  logic [7:0]        seg;

  int checks = 0;
  int errors = 0;

  // model state
  logic [LED_W-1:0] m_led = '0;
  logic [31:0]      m_hex = '0;
  logic [31:0]      m_ctrl = '0;
  logic [SW_W-1:0]  m_stable = '0;
  logic             m_changed = 1'b0;
  logic [31:0]      m_rdata = '0;
  int               edge_cnt = 0;
  logic [SW_W-1:0]  hist [DEB+2];

  mmio_io_ctrl #(
    .SW_WIDTH(SW_W), .LED_WIDTH(LED_W), .DIGITS(DIGITS), .SCAN_DIV(SCAN), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .io_write(io_write), .io_read(io_read), .addr(addr),
    .wdata(wdata), .rdata(rdata), .switch(switch), .led(led), .dig(dig), .seg(seg)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    logic [4:0] off;
    off = {a[4:2], 2'b00};
    case (off)
      5'h00:   return 32'(m_led);
      5'h04:   return m_hex;
      5'h08:   return m_ctrl;
      5'h0C:   return 32'(m_stable);
      5'h10:   return {31'b0, m_changed};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int cur_idx();
    return (edge_cnt / SCAN) % DIGITS;
  endfunction

  function automatic void exp_disp(output logic [7:0] d, output logic [7:0] s);
    int idx;
    logic [3:0] nib;
    idx = cur_idx();
    d = 8'hFF;
    s = 8'hFF;
    if (m_ctrl[idx]) begin
      d[idx] = 1'b0;
      nib = 4'(m_hex >> (4 * idx));
      s = SEG_TBL[nib];
      if (m_ctrl[8 + idx]) s[7] = 1'b0;
    end
  endfunction

  // Reference model: switch accepted after DEB equal synchronised samples, bus per register map.
  always @(posedge clk or negedge rst) begin
    logic same;
    logic set_now;
    logic [4:0] off;
    if (!rst) begin
      m_led = '0; m_hex = '0; m_ctrl = '0; m_stable = '0; m_changed = 1'b0; m_rdata = '0;
      edge_cnt = 0;
      for (int i = 0; i < DEB + 2; i++) hist[i] = '0;
    end else begin
      if (io_read) m_rdata = m_read(addr);
      for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = switch;
      same = 1'b1;
      for (int i = 3; i <= DEB + 1; i++) if (hist[i] != hist[2]) same = 1'b0;
      set_now = same && (hist[2] != m_stable);
      if (set_now) m_stable = hist[2];
      off = {addr[4:2], 2'b00};
      if (io_write) begin
        case (off)
          5'h00: m_led = wdata[LED_W-1:0];
          5'h04: m_hex = wdata;
          5'h08: m_ctrl = wdata & CTRL_MASK;
          5'h10: if (wdata[0]) m_changed = 1'b0;
          default: ;
        endcase
      end
      if (set_now) m_changed = 1'b1;
      edge_cnt++;
    end
  end

  always @(negedge clk) begin
    logic [7:0] ed, es;
    exp_disp(ed, es);
    check("rdata", rdata, m_rdata);
    check("led", 32'(led), 32'(m_led));
    check("dig", 32'(dig), 32'(ed));
    check("seg", 32'(seg), 32'(es));
  end

  // Call right after a negedge; one access, then strobes drop.
  task automatic bus(input logic wr, input logic rd, input logic [4:0] a, input logic [31:0] d);
    io_write = wr; io_read = rd; addr = a; wdata = d;
    @(negedge clk);
    io_write = 1'b0; io_read = 1'b0;
  endtask

  task automatic read_lit(input logic [4:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, 1'b1, a, 32'h0);
    check(nm, rdata, exp);
  endtask

  // New switch value sampled on edge 1; sw_stable must still be old before edge 6 and new after it.
  task automatic sw_lat(input logic [SW_W-1:0] nv, input logic [SW_W-1:0] ov, input string nm);
    switch = nv;
    for (int k = 1; k <= 7; k++) begin
      io_read = 1'b1; addr = 5'h0C;
      @(negedge clk);
      if (k == 6) check({nm, "_edge6_old"}, rdata, 32'(ov));
      if (k == 7) check({nm, "_edge7_new"}, rdata, 32'(nv));
    end
    io_read = 1'b0;
  endtask

  task automatic wait_slot(input int t, input string nm);
    int n;
    n = 0;
    while (!((edge_cnt % SCAN) == 0 && cur_idx() == t) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL %s: slot %0d not reached within 200 cycles", nm, t);
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_dig", 32'(dig), 32'hFF);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_led", 32'(led), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    read_lit(5'h00, 32'h0, "rd_led0");
    read_lit(5'h04, 32'h0, "rd_hex0");
    read_lit(5'h08, 32'h0, "rd_ctrl0");
    read_lit(5'h0C, 32'h0, "rd_sw0");
    read_lit(5'h10, 32'h0, "rd_stat0");

    // write and read of LED in the same cycle
    bus(1'b1, 1'b1, 5'h00, 32'h0000A5A5);
    check("led_same_edge", 32'(led), 32'h0000A5A5);
    check("rd_prewrite", rdata, 32'h0);
    read_lit(5'h01, 32'h0000A5A5, "rd_led_lowbits_ignored");

    // debounce latency and sticky flag
    sw_lat(24'h000002, 24'h0, "deb_2");
    read_lit(5'h10, 32'h1, "stat_set");
    bus(1'b1, 1'b0, 5'h10, 32'h1);
    read_lit(5'h10, 32'h0, "stat_cleared");

    // set and clear on the same edge: set wins
    switch = 24'h000005;
    for (int k = 1; k <= 6; k++) begin
      if (k == 6) begin io_write = 1'b1; addr = 5'h10; wdata = 32'h1; end
      @(negedge clk);
      io_write = 1'b0;
    end
    read_lit(5'h10, 32'h1, "stat_set_wins");
    read_lit(5'h0C, 32'h5, "sw_5");
    bus(1'b1, 1'b0, 5'h10, 32'h1);

    // bouncing pin never accepted
    for (int i = 0; i < 10; i++) begin
      switch = (i % 2 == 0) ? 24'h000004 : 24'h000005;
      for (int j = 0; j < 2; j++) begin
        io_read = 1'b1; addr = 5'h0C;
        @(negedge clk);
        check("sw_hold_bounce", rdata, 32'h5);
      end
    end
    io_read = 1'b0;
    sw_lat(24'h000004, 24'h000005, "deb_settle");
    read_lit(5'h14, 32'h0, "rd_unmapped");
    bus(1'b1, 1'b0, 5'h0C, 32'hFFFFFFFF);
    read_lit(5'h0C, 32'h4, "sw_readonly");

    // scanner walk
    bus(1'b1, 1'b0, 5'h04, 32'h76543210);
    bus(1'b1, 1'b0, 5'h08, 32'hFFFF01FF);
    read_lit(5'h08, 32'h000001FF, "ctrl_masked");
    wait_slot(0, "slot0");
    check("scan0_dig", 32'(dig), 32'hFE);
    check("scan0_seg", 32'(seg), 32'h40);
    repeat (3) @(negedge clk);
    check("scan0_last_dig", 32'(dig), 32'hFE);
    @(negedge clk);
    check("scan1_dig", 32'(dig), 32'hFD);
    check("scan1_seg", 32'(seg), 32'hF9);
    wait_slot(7, "slot7");
    check("scan7_dig", 32'(dig), 32'h7F);
    check("scan7_seg", 32'(seg), 32'hF8);
    repeat (4) @(negedge clk);
    check("scan_wrap_dig", 32'(dig), 32'hFE);

    // single enabled digit and mid-slot blanking
    bus(1'b1, 1'b0, 5'h08, 32'h00000004);
    wait_slot(2, "slot2");
    check("en2_dig", 32'(dig), 32'hFB);
    check("en2_seg", 32'(seg), 32'hA4);
    bus(1'b1, 1'b0, 5'h08, 32'h0);
    check("blank_dig", 32'(dig), 32'hFF);
    check("blank_seg", 32'(seg), 32'hFF);

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      io_write = ($urandom_range(0, 3) == 0);
      io_read  = ($urandom_range(0, 2) == 0);
      addr     = 5'($urandom);
      wdata    = $urandom;
      if ($urandom_range(0, 19) == 0) switch = SW_W'($urandom);
      else if ($urandom_range(0, 29) == 0) switch[$urandom_range(0, SW_W - 1)] ^= 1'b1;
      @(negedge clk);
    end
    io_write = 1'b0; io_read = 1'b0;

    // asynchronous reset mid-scan
    bus(1'b1, 1'b0, 5'h00, 32'h00123456);
    bus(1'b1, 1'b0, 5'h08, 32'h000000FF);
    bus(1'b0, 1'b1, 5'h00, 32'h0);
    check("pre_rst_rdata", rdata, 32'h00123456);
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("async_led", 32'(led), 32'h0);
    check("async_rdata", rdata, 32'h0);
    check("async_dig", 32'(dig), 32'hFF);
    check("async_seg", 32'(seg), 32'hFF);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    read_lit(5'h00, 32'h0, "post_rst_led");
    read_lit(5'h08, 32'h0, "post_rst_ctrl");
    read_lit(5'h10, 32'h0, "post_rst_stat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

endmodule
